ms_countdown: RTL and testbench
===============================

# ms_countdown

Loadable millisecond countdown timer. Consumes the one-cycle `ms_event` tick from the 1 ms timer and counts down from a programmed value, which is the opposite of the up-counting millisecond counter. On reaching zero it raises a one-cycle `expired` pulse. It supports one-shot and auto-reload (periodic) modes and is the timeout/alarm source for control logic in the same clock domain.

## Interface
- `WIDTH`, default 8: width of the load value and the remaining-count register.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `ms_event` in 1: one-cycle tick, one per millisecond; other cycles 0.
- `start` in 1: one-cycle command; loads `load_val` and arms the timer.
- `stop` in 1: one-cycle command; aborts the countdown.
- `load_val` in WIDTH: countdown length in ms; sampled only when `start`=1.
- `reload_en` in 1: periodic-mode select; sampled only when `start`=1.
- `busy` out 1: 1 while in RUN.
- `expired` out 1: one-cycle pulse when the count reaches zero.
- `cnt_left` out WIDTH: remaining ms.

## Operation
- Internal registers:
  - state: IDLE or RUN.
  - `period` (WIDTH): captured `load_val`.
  - `mode_reload` (1): captured `reload_en`.
  - `cnt_left`.
- All outputs are registered. None depends combinationally on the inputs.
- Per-cycle priority: `stop` > `start` > `ms_event`.
- IDLE:
  - `start`, `load_val`≠0: `period`←`load_val`, `cnt_left`←`load_val`, `mode_reload`←`reload_en`, go to RUN.
  - `start`, `load_val`=0: `expired`=1 for one cycle, `cnt_left`←0, stay in IDLE (zero-length timeout; no periodic mode).
  - `ms_event` alone: ignored.
- RUN:
  - `stop`=1: go to IDLE, `cnt_left` holds its current value, no `expired`.
  - `start`=1: restart with the new `load_val`/`reload_en` as in IDLE. A coincident `ms_event` is ignored.
  - `ms_event`=1, `cnt_left`>1: `cnt_left`←`cnt_left`−1.
  - `ms_event`=1, `cnt_left`=1: `expired`=1.
    - `mode_reload`=1: `cnt_left`←`period`, stay in RUN.
    - Otherwise: `cnt_left`←0, go to IDLE.
- Arithmetic:
  - Unsigned WIDTH-bit values.
  - Decrement never wraps: in RUN, `cnt_left` is always ≥1 before a tick.
  - Maximum timeout is 2^WIDTH−1 ms.
- Outputs:
  - `busy` = (state==RUN).
  - `expired` defaults to 0 every cycle unless set by the rules above.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, `cnt_left`=0, `period`=0, `mode_reload`=0, `busy`=0, `expired`=0. All are held while `rst`=0.
- Reset release: the first active edge is the first rising `clk` edge with `rst`=1.
- Reset mid-count: the countdown is lost immediately, with no `expired`.
- `start` at edge k: from cycle k+1, `busy`=1 and `cnt_left`=`load_val`.
- Each `ms_event` at edge k: `cnt_left` is updated in cycle k+1.
- Expiry at edge k:
  - Cycle k+1: `expired`=1, `cnt_left` shows 0 (one-shot) or `period` (reload).
  - One-shot: `busy`=0 in cycle k+1.
  - Reload: `busy` stays 1.
- One-shot of N ms: `expired` comes exactly N `ms_event` pulses after `start`.
- Periodic mode: `expired` repeats every N pulses with no lost tick across the reload.
- `expired` is never high for two consecutive cycles unless consecutive cycles carry qualifying events.

## Test plan
- Reset, then `start` with `load_val`=3, `reload_en`=0, then 3 `ms_event` pulses 5 cycles apart → `cnt_left` reads 3, 2, 1, 0. `expired` is high one cycle together with 0. `busy` goes 1→0 in that cycle.
- `start` with `load_val`=2, `reload_en`=1, then 6 ticks → `expired` after ticks 2, 4 and 6. `cnt_left` reads 2 after each. `busy` stays 1.
- `start` with 5, 2 ticks, then `stop` coincident with a tick → IDLE, `cnt_left`=3, no `expired`. Further ticks leave `cnt_left`=3.
- `start` with 4, 1 tick, then `start` with 10 coincident with a tick → `cnt_left`=10, `busy`=1.
- `start` with `load_val`=0 → single `expired` pulse, `busy`=0, `cnt_left`=0. `start`+`stop` in the same cycle → no change.
- WIDTH=8, `start` with 255, assert `rst`=0 asynchronously after 100 ticks → all outputs 0 at once. After release, ticks have no effect.

Source files
------------

// File: rtl/ms_countdown.sv
// Loadable millisecond countdown timer: counts ms_event ticks down from a programmed
// value and pulses expired on reaching zero, in one-shot or auto-reload mode.
module ms_countdown #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ms_event,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] load_val,
  input  logic             reload_en,
  output logic             busy,
  output logic             expired,
  output logic [WIDTH-1:0] cnt_left
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_reload_q, mode_reload_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      period_q      <= '0;
      mode_reload_q <= 1'b0;
      cnt_q         <= '0;
      expired_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      mode_reload_q <= mode_reload_d;
      cnt_q         <= cnt_d;
      expired_q     <= expired_d;
    end
  end

  // Priority stop > start > ms_event; a running count is always >= 1, so no wrap.
  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    mode_reload_d = mode_reload_q;
    cnt_d         = cnt_q;
    expired_d     = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      if (load_val == '0) begin
        expired_d = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end else begin
        period_d      = load_val;
        cnt_d         = load_val;
        mode_reload_d = reload_en;
        state_d       = RUN;
      end
    end else if (ms_event && (state_q == RUN)) begin
      if (cnt_q == WIDTH'(1)) begin
        expired_d = 1'b1;
        if (mode_reload_q) begin
          cnt_d = period_q;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  assign busy     = (state_q == RUN);
  assign expired  = expired_q;
  assign cnt_left = cnt_q;

endmodule

// File: tb/tb_ms_countdown.sv
// Directed and randomized bench for ms_countdown against a behavioural timer model.
module tb_ms_countdown;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ms_event = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         reload_en = 1'b0;
  logic         busy;
  logic         expired;
  logic [W-1:0] cnt_left;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: a running flag plus milliseconds left
  bit       m_run;
  int       m_left;
  int       m_period;
  bit       m_reload;
  bit       m_exp;
  int       ticks_since_arm;

  ms_countdown #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ms_event(ms_event), .start(start), .stop(stop),
    .load_val(load_val), .reload_en(reload_en),
    .busy(busy), .expired(expired), .cnt_left(cnt_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_left = 0; m_period = 0; m_reload = 0; m_exp = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, m_run});
    chk({tag, "_expired"}, {31'd0, expired}, {31'd0, m_exp});
    chk({tag, "_cnt"}, {24'd0, cnt_left}, m_left);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic step(input string tag, input bit st, input bit sp, input bit ev,
                      input int lv, input bit re);
    bit tick_expiry;
    start = st; stop = sp; ms_event = ev; load_val = W'(lv); reload_en = re;
    @(posedge clk);
    tick_expiry = 0;
    m_exp = 0;
    if (!rst) begin
      model_reset();
    end else if (sp) begin
      m_run = 0;
    end else if (st) begin
      ticks_since_arm = 0;
      if (lv == 0) begin
        m_exp = 1; m_left = 0; m_run = 0;
      end else begin
        m_period = lv; m_left = lv; m_reload = re; m_run = 1;
      end
    end else if (ev && m_run) begin
      ticks_since_arm++;
      if (m_left == 1) begin
        m_exp = 1;
        tick_expiry = 1;
        m_left = m_reload ? m_period : 0;
        m_run  = m_reload;
      end else begin
        m_left = m_left - 1;
      end
    end
    #1;
    check_outputs(tag);
    if (tick_expiry && expired === 1'b1) begin
      chk({tag, "_interval"}, ticks_since_arm, m_period);
      ticks_since_arm = 0;
    end
    start = 0; stop = 0; ms_event = 0; reload_en = 0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    ticks_since_arm = 0;

    // Reset held across clock edges
    #12;
    check_outputs("reset");
    rst = 1'b1;

    // One-shot of 3 ms, ticks 5 cycles apart
    step("os_start", 1, 0, 0, 3, 0);
    chk("os_cnt3", {24'd0, cnt_left}, 3);
    for (int t = 0; t < 3; t++) begin
      idle("os_gap", 4);
      step("os_tick", 0, 0, 1, 0, 0);
    end
    chk("os_exp_pulse", {31'd0, expired}, 1);
    chk("os_cnt0", {24'd0, cnt_left}, 0);
    chk("os_busy0", {31'd0, busy}, 0);
    idle("os_after", 2);

    // Periodic mode: period 2, 6 ticks
    step("per_start", 1, 0, 0, 2, 1);
    for (int t = 0; t < 6; t++) begin
      step("per_tick", 0, 0, 1, 0, 0);
      idle("per_gap", 1);
    end
    chk("per_busy", {31'd0, busy}, 1);
    chk("per_cnt", {24'd0, cnt_left}, 2);

    // Stop coincident with a tick
    step("stop_start", 1, 0, 0, 5, 0);
    step("stop_tick", 0, 0, 1, 0, 0);
    step("stop_tick", 0, 0, 1, 0, 0);
    step("stop_cmd", 0, 1, 1, 0, 0);
    chk("stop_cnt3", {24'd0, cnt_left}, 3);
    step("stop_ign", 0, 0, 1, 0, 0);
    step("stop_ign", 0, 0, 1, 0, 0);
    chk("stop_hold3", {24'd0, cnt_left}, 3);

    // Restart coincident with a tick
    step("rs_start", 1, 0, 0, 4, 0);
    step("rs_tick", 0, 0, 1, 0, 0);
    step("rs_restart", 1, 0, 1, 10, 0);
    chk("rs_cnt10", {24'd0, cnt_left}, 10);
    chk("rs_busy", {31'd0, busy}, 1);
    step("stop_rs", 0, 1, 0, 0, 0);

    // Zero-length timeout, then start+stop together
    step("zero_start", 1, 0, 0, 0, 1);
    chk("zero_exp", {31'd0, expired}, 1);
    step("zero_after", 0, 0, 1, 0, 0);
    step("ss_both", 1, 1, 0, 7, 0);
    chk("ss_busy", {31'd0, busy}, 0);

    // Maximum load, asynchronous reset mid-count
    step("max_start", 1, 0, 0, 255, 0);
    for (int t = 0; t < 100; t++) step("max_tick", 0, 0, 1, 0, 0);
    chk("max_cnt155", {24'd0, cnt_left}, 155);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    idle("rst_hold", 2);
    rst = 1'b1;
    for (int t = 0; t < 3; t++) step("post_rst_tick", 0, 0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit st, sp, ev, re;
      int lv;
      ev = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 24) == 0);
      sp = ($urandom_range(0, 59) == 0);
      re = $urandom_range(0, 1);
      lv = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      step("rand", st, sp, ev, lv, re);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
